axis_group_distributor: RTL and testbench
=========================================

Name: axis_group_distributor

Overview:
- N-way successor to the two-way group ping-pong splitter.
- Takes one AXI-Stream input and sends whole groups of packets to NUM_OUTPUTS output streams in round-robin order.
- Outputs can be skipped through a per-output enable mask, which is sampled at group boundaries.
- Has a registered skid-buffered output stage for timing closure, and sits between the packet source and parallel downstream consumers.

Parameters:
- STREAM_WBITS, 512, TDATA width in bits.
- NUM_OUTPUTS, 4, number of output streams; legal range 2..16.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- AXIS_IN_TDATA  input  STREAM_WBITS  input data.
- AXIS_IN_TVALID  input  1  input valid.
- AXIS_IN_TLAST  input  1  end of packet.
- AXIS_IN_TREADY  output  1  input ready.
- AXIS_OUT_TDATA  output  NUM_OUTPUTS*STREAM_WBITS  per-output data; lane i is bits [i*W +: W].
- AXIS_OUT_TLAST  output  NUM_OUTPUTS  per-output end of packet.
- AXIS_OUT_TVALID  output  NUM_OUTPUTS  per-output valid.
- AXIS_OUT_TREADY  input  NUM_OUTPUTS  per-output ready.
- PACKETS_PER_GROUP  input  32  packets per group; 0 is treated as 1.
- OUTPUT_ENABLE  input  NUM_OUTPUTS  1 = output participates in rotation.
- CURRENT_OUTPUT  output  SELW  index of the output currently receiving; SELW = $clog2(NUM_OUTPUTS).
- GROUPS_DONE  output  32  count of completed groups; wraps at 2^32.

Behaviour:

Reset (async, resetn=0):
- AXIS_IN_TREADY=0.
- All AXIS_OUT_TVALID, AXIS_OUT_TLAST and AXIS_OUT_TDATA = 0.
- CURRENT_OUTPUT=0, GROUPS_DONE=0.
- State=SELECT with search start index 0.
- Skid buffer is emptied; in-flight beats are discarded.

State machine, two states:
- SELECT: AXIS_IN_TREADY=0.
  - If OUTPUT_ENABLE is nonzero: pick the lowest enabled index >= start, wrapping modulo NUM_OUTPUTS. Latch it into CURRENT_OUTPUT. Latch group size = max(PACKETS_PER_GROUP,1). Load packet counter = 1. Go to RUN.
  - If OUTPUT_ENABLE is all zero: stay in SELECT and re-evaluate every cycle.
  - SELECT always costs exactly one cycle when a target exists.
- RUN: AXIS_IN_TREADY = skid buffer not full.
  - Each accepted beat enters the buffer tagged with CURRENT_OUTPUT.
  - On an accepted beat with TLAST=1:
    - If counter < latched size: counter+1.
    - Otherwise: GROUPS_DONE+1, start = (CURRENT_OUTPUT+1) mod NUM_OUTPUTS, go to SELECT.
- Changes to PACKETS_PER_GROUP or OUTPUT_ENABLE during RUN have no effect until the next SELECT.
- Disabling the current output mid-group does not abort the group.

Output stage:
- Two-entry skid buffer. Input-to-output latency is 1 cycle.
- Full throughput of 1 beat/cycle while the destination ready is held high.
- Head entry with tag d:
  - AXIS_OUT_TVALID[d]=1; all other TVALID bits are 0.
  - Data and TLAST appear only on lane d; other lanes are driven to 0.
- Head pops on AXIS_OUT_TVALID[d] & AXIS_OUT_TREADY[d].
- Ready on non-selected lanes is ignored.
- Beats from consecutive groups can coexist in the buffer with different tags. Each beat leaves only on its own tagged output, in order.
- Once asserted, TVALID and the payload stay stable until the handshake completes.
- Simultaneous push and pop on a full buffer is not permitted: TREADY is already 0 when the buffer is full.
- The registered TREADY is recomputed from fill level after push/pop each cycle.

Width rules:
- Packet counter is 32 bits; comparison is unsigned.
- NUM_OUTPUTS need not be a power of 2: index wrap uses an explicit compare, not truncation.

Decomposition:
- Shared package axis_pkg holds:
  - function clog2_min1 (SELW for NUM_OUTPUTS>=2);
  - state enum constants ST_SELECT / ST_RUN;
  - function next_enabled(start, mask), the wrapping priority search.
- One sub-module, axis_skid_buffer: a 2-entry buffer carrying {tag, tlast, tdata}, with parametrised payload width.

Test Plan:
1. NUM_OUTPUTS=4, mask=4'b1111, PPG=2, 8 one-beat packets, all ready=1 -> packets 1-2 on out0, 3-4 on out1, 5-6 on out2, 7-8 on out3; GROUPS_DONE=4; one-cycle TREADY gap after each group.
2. Mask=4'b1010, PPG=1, 4 packets of 3 beats -> order out1, out3, out1, out3; only the TVALID bit of the tagged lane ever asserts; other lanes' TDATA=0.
3. PPG=0, 3 packets -> treated as 1: out0, out1, out2; GROUPS_DONE=3.
4. Mask=0 after reset, drive TVALID=1 for 20 cycles -> TREADY stays 0. Then set mask=4'b0100 -> CURRENT_OUTPUT=2 on the next cycle and data is accepted the cycle after.
5. Streaming with out0 ready toggling 1,0,0,1 -> no beat lost or duplicated, payload stable while stalled, TREADY drops only when the buffer holds 2 entries; check against a scoreboard.
6. Assert resetn=0 mid-packet with the buffer full -> all TVALID=0 and TREADY=0 immediately (async). After release, rotation restarts at out0 and GROUPS_DONE=0.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream group distributor.
// Holds the FSM state enum, select-width helper and the wrapping priority search.
package axis_pkg;

   typedef enum logic {
      ST_SELECT = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   localparam int MAX_OUTPUTS = 16;

   // Select width, never below one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Lowest set mask bit at or after start, wrapping modulo n.
   // Wrap is an explicit compare so non-power-of-2 n works.
   function automatic logic [3:0] next_enabled(
      input logic [3:0]  start,
      input logic [15:0] mask,
      input int          n
   );
      logic [3:0] res;
      logic       found;
      int         idx;
      res   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_OUTPUTS; i++) begin
         if (i < n) begin
            idx = int'(start) + i;
            if (idx >= n) idx = idx - n;
            if (!found && mask[idx[3:0]]) begin
               res   = idx[3:0];
               found = 1'b1;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer; head entry is presented on dout_o while valid_o is high.
// Ports: push_i/din_i write, pop_i/dout_o/valid_o read, full_o when both entries hold data.
module axis_skid_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         valid_o,
   output logic         full_o
);

   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop_i & (cnt_q != 2'd0);
   assign do_push = push_i & (cnt_q != 2'd2);

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      unique case ({do_push, do_pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = din_i;
            else               tail_d = din_i;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
         end
         // Push with pop only happens at one entry: the new beat becomes head.
         2'b11: head_d = din_i;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout_o  = head_q;
   assign valid_o = (cnt_q != 2'd0);
   assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/axis_group_distributor.sv
// Round-robin distributor of whole packet groups from one AXI-Stream input to N outputs.
// Ports: AXIS_IN_* input stream, AXIS_OUT_* lane-packed outputs, PACKETS_PER_GROUP,
// OUTPUT_ENABLE mask, CURRENT_OUTPUT target index, GROUPS_DONE completed-group count.
module axis_group_distributor
   import axis_pkg::*;
#(
   parameter  int STREAM_WBITS = 512,
   parameter  int NUM_OUTPUTS  = 4,
   localparam int SELW         = clog2_min1(NUM_OUTPUTS)
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic [STREAM_WBITS-1:0]           AXIS_IN_TDATA,
   input  logic                              AXIS_IN_TVALID,
   input  logic                              AXIS_IN_TLAST,
   output logic                              AXIS_IN_TREADY,
   output logic [NUM_OUTPUTS*STREAM_WBITS-1:0] AXIS_OUT_TDATA,
   output logic [NUM_OUTPUTS-1:0]            AXIS_OUT_TLAST,
   output logic [NUM_OUTPUTS-1:0]            AXIS_OUT_TVALID,
   input  logic [NUM_OUTPUTS-1:0]            AXIS_OUT_TREADY,
   input  logic [31:0]                       PACKETS_PER_GROUP,
   input  logic [NUM_OUTPUTS-1:0]            OUTPUT_ENABLE,
   output logic [SELW-1:0]                   CURRENT_OUTPUT,
   output logic [31:0]                       GROUPS_DONE
);

   localparam int W  = STREAM_WBITS;
   localparam int PW = SELW + 1 + W;

   state_t          state_q, state_d;
   logic [SELW-1:0] start_q, start_d;
   logic [SELW-1:0] cur_q, cur_d;
   logic [31:0]     size_q, size_d;
   logic [31:0]     cnt_q, cnt_d;
   logic [31:0]     groups_q, groups_d;

   logic            accept;
   logic            buf_full;
   logic            buf_valid;
   logic            buf_pop;
   logic [PW-1:0]   buf_dout;
   logic [SELW-1:0] buf_tag;
   logic            buf_last;
   logic [W-1:0]    buf_data;

   assign AXIS_IN_TREADY = (state_q == ST_RUN) & ~buf_full;
   assign accept         = AXIS_IN_TVALID & AXIS_IN_TREADY;

   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      cur_d    = cur_q;
      size_d   = size_q;
      cnt_d    = cnt_q;
      groups_d = groups_q;
      unique case (state_q)
         ST_SELECT: begin
            if (|OUTPUT_ENABLE) begin
               cur_d   = SELW'(next_enabled(4'(start_q),
                                            16'(OUTPUT_ENABLE),
                                            NUM_OUTPUTS));
               size_d  = (PACKETS_PER_GROUP == 32'd0) ? 32'd1
                                                      : PACKETS_PER_GROUP;
               cnt_d   = 32'd1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept && AXIS_IN_TLAST) begin
               if (cnt_q < size_q) begin
                  cnt_d = cnt_q + 32'd1;
               end else begin
                  groups_d = groups_q + 32'd1;
                  start_d  = (cur_q == SELW'(NUM_OUTPUTS - 1)) ? '0
                                                               : cur_q + 1'b1;
                  state_d  = ST_SELECT;
               end
            end
         end
         default: state_d = ST_SELECT;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_SELECT;
         start_q  <= '0;
         cur_q    <= '0;
         size_q   <= 32'd1;
         cnt_q    <= 32'd1;
         groups_q <= '0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         cur_q    <= cur_d;
         size_q   <= size_d;
         cnt_q    <= cnt_d;
         groups_q <= groups_d;
      end
   end

   axis_skid_buffer #(
      .W (PW)
   ) u_skid (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (accept),
      .din_i   ({cur_q, AXIS_IN_TLAST, AXIS_IN_TDATA}),
      .pop_i   (buf_pop),
      .dout_o  (buf_dout),
      .valid_o (buf_valid),
      .full_o  (buf_full)
   );

   assign {buf_tag, buf_last, buf_data} = buf_dout;

   // Only the tagged lane ever shows valid, so OR-reducing handshakes
   // ignores ready on every other lane.
   assign buf_pop = |(AXIS_OUT_TVALID & AXIS_OUT_TREADY);

   for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_lane
      logic hit;
      assign hit                       = buf_valid & (buf_tag == SELW'(i));
      assign AXIS_OUT_TVALID[i]        = hit;
      assign AXIS_OUT_TLAST[i]         = hit & buf_last;
      assign AXIS_OUT_TDATA[i*W +: W]  = hit ? buf_data : '0;
   end

   assign CURRENT_OUTPUT = cur_q;
   assign GROUPS_DONE    = groups_q;

endmodule

// File: tb/tb_axis_group_distributor.sv
// Directed self-checking bench for axis_group_distributor (4 outputs, 32-bit data).
// A negedge monitor logs output beats and checks lane isolation, stall stability and fill-based ready.
module tb_axis_group_distributor;

   localparam int W    = 32;
   localparam int N    = 4;
   localparam int SELW = 2;

   logic            clk = 1'b0;
   logic            resetn;
   logic [W-1:0]    AXIS_IN_TDATA;
   logic            AXIS_IN_TVALID;
   logic            AXIS_IN_TLAST;
   logic            AXIS_IN_TREADY;
   logic [N*W-1:0]  AXIS_OUT_TDATA;
   logic [N-1:0]    AXIS_OUT_TLAST;
   logic [N-1:0]    AXIS_OUT_TVALID;
   logic [N-1:0]    AXIS_OUT_TREADY;
   logic [31:0]     PACKETS_PER_GROUP;
   logic [N-1:0]    OUTPUT_ENABLE;
   logic [SELW-1:0] CURRENT_OUTPUT;
   logic [31:0]     GROUPS_DONE;

   axis_group_distributor #(
      .STREAM_WBITS (W),
      .NUM_OUTPUTS  (N)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .AXIS_IN_TDATA     (AXIS_IN_TDATA),
      .AXIS_IN_TVALID    (AXIS_IN_TVALID),
      .AXIS_IN_TLAST     (AXIS_IN_TLAST),
      .AXIS_IN_TREADY    (AXIS_IN_TREADY),
      .AXIS_OUT_TDATA    (AXIS_OUT_TDATA),
      .AXIS_OUT_TLAST    (AXIS_OUT_TLAST),
      .AXIS_OUT_TVALID   (AXIS_OUT_TVALID),
      .AXIS_OUT_TREADY   (AXIS_OUT_TREADY),
      .PACKETS_PER_GROUP (PACKETS_PER_GROUP),
      .OUTPUT_ENABLE     (OUTPUT_ENABLE),
      .CURRENT_OUTPUT    (CURRENT_OUTPUT),
      .GROUPS_DONE       (GROUPS_DONE)
   );

   always #5 clk = ~clk;

   int           n_assert = 0;
   int           n_fail   = 0;
   int           q_lane[$];
   logic [W-1:0] q_data[$];
   logic         q_last[$];
   int           occ = 0;
   bit           chk_rdy = 1'b0;
   bit           saw_full = 1'b0;
   bit           pat_en = 1'b0;
   logic [1:0]   pcyc = 2'd0;
   logic [3:0]   pat = 4'b1001;
   bit           pv = 1'b0;
   int           plane = 0;
   logic [W-1:0] pdata = '0;
   logic         plast = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (pat_en) begin
         AXIS_OUT_TREADY[0] = pat[pcyc];
         pcyc = pcyc + 2'd1;
      end
   endtask

   task automatic send(input logic [W-1:0] d, input logic l, output int stalls);
      bit r;
      bit done;
      AXIS_IN_TDATA  = d;
      AXIS_IN_TLAST  = l;
      AXIS_IN_TVALID = 1'b1;
      stalls = 0;
      done   = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         r = AXIS_IN_TREADY;
         step();
         if (r) done = 1'b1;
         else   stalls++;
      end
      AXIS_IN_TVALID = 1'b0;
      if (!done) chk("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic do_reset(input logic [N-1:0] m, input logic [31:0] ppg);
      resetn            = 1'b0;
      AXIS_IN_TVALID    = 1'b0;
      AXIS_IN_TDATA     = '0;
      AXIS_IN_TLAST     = 1'b0;
      AXIS_OUT_TREADY   = '1;
      OUTPUT_ENABLE     = m;
      PACKETS_PER_GROUP = ppg;
      pat_en            = 1'b0;
      chk_rdy           = 1'b0;
      step();
      step();
      resetn = 1'b1;
      step();
      step();
      q_lane.delete();
      q_data.delete();
      q_last.delete();
   endtask

   always @(negedge clk) begin
      bit out_hs;
      if (!resetn) begin
         occ = 0;
         pv  = 1'b0;
      end else begin
         chk("onehot_valid", 64'($onehot0(AXIS_OUT_TVALID)), 64'(1));
         for (int i = 0; i < N; i++)
            if (!AXIS_OUT_TVALID[i])
               chk("idle_lane_zero",
                   64'({AXIS_OUT_TLAST[i], AXIS_OUT_TDATA[i*W +: W]}), 64'(0));
         if (pv)
            chk("stall_stable",
                64'({AXIS_OUT_TVALID[plane], AXIS_OUT_TLAST[plane],
                     AXIS_OUT_TDATA[plane*W +: W]}),
                64'({1'b1, plast, pdata}));
         if (chk_rdy) begin
            chk("tready_vs_fill", 64'(AXIS_IN_TREADY), 64'(occ != 2));
            if (occ == 2) saw_full = 1'b1;
         end
         pv     = 1'b0;
         out_hs = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (AXIS_OUT_TVALID[i]) begin
               if (AXIS_OUT_TREADY[i]) begin
                  q_lane.push_back(i);
                  q_data.push_back(AXIS_OUT_TDATA[i*W +: W]);
                  q_last.push_back(AXIS_OUT_TLAST[i]);
                  out_hs = 1'b1;
               end else begin
                  pv    = 1'b1;
                  plane = i;
                  pdata = AXIS_OUT_TDATA[i*W +: W];
                  plast = AXIS_OUT_TLAST[i];
               end
            end
         end
         occ = occ + ((AXIS_IN_TVALID && AXIS_IN_TREADY) ? 1 : 0)
                   - (out_hs ? 1 : 0);
      end
   end

   initial begin
      int s;
      int exp_lane;

      // Reset state
      resetn            = 1'b0;
      AXIS_IN_TVALID    = 1'b0;
      AXIS_IN_TDATA     = '0;
      AXIS_IN_TLAST     = 1'b0;
      AXIS_OUT_TREADY   = '1;
      OUTPUT_ENABLE     = 4'b1111;
      PACKETS_PER_GROUP = 32'd2;
      step();
      chk("rst_tready", 64'(AXIS_IN_TREADY), 64'(0));
      chk("rst_tvalid", 64'(AXIS_OUT_TVALID), 64'(0));
      chk("rst_tlast", 64'(AXIS_OUT_TLAST), 64'(0));
      chk("rst_tdata", 64'(|AXIS_OUT_TDATA), 64'(0));
      chk("rst_cur", 64'(CURRENT_OUTPUT), 64'(0));
      chk("rst_groups", 64'(GROUPS_DONE), 64'(0));

      // 1: four outputs, two packets per group
      do_reset(4'b1111, 32'd2);
      for (int k = 0; k < 8; k++) begin
         send(W'(k), 1'b1, s);
         chk("t1_stall", 64'(s), 64'((k == 2 || k == 4 || k == 6) ? 1 : 0));
      end
      repeat (3) step();
      chk("t1_count", 64'(q_lane.size()), 64'(8));
      for (int k = 0; k < 8; k++) begin
         chk("t1_lane", 64'(q_lane[k]), 64'(k / 2));
         chk("t1_data", 64'(q_data[k]), 64'(k));
      end
      chk("t1_groups", 64'(GROUPS_DONE), 64'(4));
      chk("t1_cur_wrap", 64'(CURRENT_OUTPUT), 64'(0));

      // 2: sparse mask, single-packet groups of 3 beats
      do_reset(4'b1010, 32'd1);
      for (int j = 0; j < 12; j++)
         send(W'(100 + j), (j % 3) == 2, s);
      repeat (3) step();
      chk("t2_count", 64'(q_lane.size()), 64'(12));
      for (int j = 0; j < 12; j++) begin
         exp_lane = ((j / 3) % 2 == 0) ? 1 : 3;
         chk("t2_lane", 64'(q_lane[j]), 64'(exp_lane));
         chk("t2_data", 64'(q_data[j]), 64'(100 + j));
         chk("t2_last", 64'(q_last[j]), 64'((j % 3) == 2));
      end
      chk("t2_groups", 64'(GROUPS_DONE), 64'(4));

      // 3: zero group size behaves as one
      do_reset(4'b1111, 32'd0);
      for (int k = 0; k < 3; k++) send(W'(200 + k), 1'b1, s);
      repeat (3) step();
      chk("t3_count", 64'(q_lane.size()), 64'(3));
      for (int k = 0; k < 3; k++) chk("t3_lane", 64'(q_lane[k]), 64'(k));
      chk("t3_groups", 64'(GROUPS_DONE), 64'(3));

      // 4: empty mask blocks input until an output is enabled
      do_reset(4'b0000, 32'd1);
      AXIS_IN_TDATA  = 32'hAB;
      AXIS_IN_TLAST  = 1'b1;
      AXIS_IN_TVALID = 1'b1;
      for (int k = 0; k < 20; k++) begin
         chk("t4_blocked", 64'(AXIS_IN_TREADY), 64'(0));
         step();
      end
      chk("t4_no_out", 64'(AXIS_OUT_TVALID), 64'(0));
      OUTPUT_ENABLE = 4'b0100;
      step();
      chk("t4_cur", 64'(CURRENT_OUTPUT), 64'(2));
      chk("t4_ready", 64'(AXIS_IN_TREADY), 64'(1));
      step();
      AXIS_IN_TVALID = 1'b0;
      chk("t4_valid", 64'(AXIS_OUT_TVALID), 64'(4'b0100));
      chk("t4_data", 64'(AXIS_OUT_TDATA[2*W +: W]), 64'(32'hAB));
      chk("t4_last", 64'(AXIS_OUT_TLAST), 64'(4'b0100));
      step();

      // 5: streaming against a toggling ready
      do_reset(4'b0001, 32'd1000);
      saw_full = 1'b0;
      pcyc     = 2'd0;
      pat_en   = 1'b1;
      chk_rdy  = 1'b1;
      for (int k = 0; k < 12; k++) send(W'(32'h500 + k), 1'b1, s);
      repeat (12) step();
      chk_rdy = 1'b0;
      pat_en  = 1'b0;
      AXIS_OUT_TREADY = '1;
      repeat (2) step();
      chk("t5_count", 64'(q_lane.size()), 64'(12));
      for (int k = 0; k < 12; k++) begin
         chk("t5_lane", 64'(q_lane[k]), 64'(0));
         chk("t5_data", 64'(q_data[k]), 64'(32'h500 + k));
      end
      chk("t5_saw_full", 64'(saw_full), 64'(1));
      chk("t5_groups", 64'(GROUPS_DONE), 64'(0));

      // 6: async reset with a full buffer
      do_reset(4'b1111, 32'd1);
      send(W'(32'h600), 1'b1, s);
      repeat (2) step();
      chk("t6_groups_pre", 64'(GROUPS_DONE), 64'(1));
      chk("t6_cur_pre", 64'(CURRENT_OUTPUT), 64'(1));
      AXIS_OUT_TREADY = '0;
      AXIS_IN_TVALID  = 1'b1;
      AXIS_IN_TLAST   = 1'b0;
      AXIS_IN_TDATA   = 32'h601;
      step();
      AXIS_IN_TDATA   = 32'h602;
      step();
      AXIS_IN_TDATA   = 32'h603;
      chk("t6_full_ready", 64'(AXIS_IN_TREADY), 64'(0));
      chk("t6_full_valid", 64'(AXIS_OUT_TVALID), 64'(4'b0010));
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_async_valid", 64'(AXIS_OUT_TVALID), 64'(0));
      chk("t6_async_ready", 64'(AXIS_IN_TREADY), 64'(0));
      chk("t6_async_data", 64'(|AXIS_OUT_TDATA), 64'(0));
      chk("t6_async_cur", 64'(CURRENT_OUTPUT), 64'(0));
      AXIS_IN_TVALID  = 1'b0;
      AXIS_OUT_TREADY = '1;
      step();
      resetn = 1'b1;
      repeat (2) step();
      q_lane.delete();
      q_data.delete();
      q_last.delete();
      chk("t6_groups_post", 64'(GROUPS_DONE), 64'(0));
      chk("t6_cur_post", 64'(CURRENT_OUTPUT), 64'(0));
      send(W'(32'h610), 1'b1, s);
      repeat (3) step();
      chk("t6_count", 64'(q_lane.size()), 64'(1));
      chk("t6_lane", 64'(q_lane[0]), 64'(0));
      chk("t6_data", 64'(q_data[0]), 64'(32'h610));
      chk("t6_groups_end", 64'(GROUPS_DONE), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
